// File: rtl/pipe_add_atr_pkg.sv
// ============================================================================
// Module   : pipe_add_atr_pkg
// Brief    : Shared defaults, stage control record and offset helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_add_atr_pkg;

    localparam int W_DEF      = 16;
    localparam int STAGES_DEF = 4;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int chunk_width(input int w, input int stages);
        return w / stages;
    endfunction

    // Stage k keeps (k+1) finished sum chunks; offsets pack them back to back.
    function automatic int lo_off(input int k, input int cw);
        return (cw * k * (k + 1)) / 2;
    endfunction

    // Stage k keeps W-(k+1)*CW not-yet-added operand bits.
    function automatic int hi_off(input int k, input int w, input int cw);
        return (k * w) - ((cw * k * (k + 1)) / 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_add_atr_chunk.sv
// ============================================================================
// Module   : pipe_add_atr_chunk
// Brief    : CW-bit combinational adder slice with carry out and carry into MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_add_atr_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    logic [CW:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum    = w_full[CW-1:0];
    assign cout   = w_full[CW];
    assign c_msb  = sum[CW-1] ^ a[CW-1] ^ b[CW-1];

endmodule

`default_nettype wire

// File: rtl/pipe_add_atr.sv
// ============================================================================
// Module   : pipe_add_atr
// Brief    : Pipelined W-bit add/sub, one carry chunk per stage, valid/ready.
//            Define PIPE_ADD_ATR_SAT_EN for saturation (sat_mode in, sat out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_add_atr
    import pipe_add_atr_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         sub,
`ifdef PIPE_ADD_ATR_SAT_EN
    input  logic         sat_mode,
    output logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         ovf
);

    localparam int CW    = chunk_width(W, STAGES);
    localparam int TOT_S = lo_off(STAGES, CW);
    localparam int TOT_A = (STAGES > 1) ? hi_off(STAGES, W, CW) : 1;
    localparam int OPN   = (STAGES > 1) ? STAGES - 1 : 1;

    stage_ctl_t [STAGES-1:0] r_ctl;
    logic [TOT_S-1:0]        r_sum_all;
    logic [TOT_A-1:0]        r_a_all;
    logic [TOT_A-1:0]        r_b_all;
    logic                    r_ovf;
    logic [STAGES:0]         w_adv;
    logic [W-1:0]            w_beff;
`ifdef PIPE_ADD_ATR_SAT_EN
    logic [OPN-1:0]          r_sub;
    logic [OPN-1:0]          r_smode;
    logic                    r_sat;
`endif

    // Advance ripples back from the consumer; an empty stage always advances.
    always_comb begin
        w_adv         = '0;
        w_adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k] = ~r_ctl[k].valid | w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0];
    assign w_beff   = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO     = (k + 1) * CW;
        localparam int LO_OFF = lo_off(k, CW);

        logic [CW-1:0] w_ca;
        logic [CW-1:0] w_cb;
        logic [CW-1:0] w_cs;
        logic          w_cin;
        logic          w_cout;
        logic          w_cmsb;
        logic          w_vin;
        logic [LO-1:0] w_lo_next;
        logic [LO-1:0] w_lo_store;
`ifdef PIPE_ADD_ATR_SAT_EN
        logic          w_sub_in;
        logic          w_smode_in;
`endif

        if (k == 0) begin : g_first
            assign w_ca      = a[CW-1:0];
            assign w_cb      = w_beff[CW-1:0];
            assign w_cin     = sub | ci;
            assign w_vin     = in_valid;
            assign w_lo_next = w_cs;
`ifdef PIPE_ADD_ATR_SAT_EN
            assign w_sub_in   = sub;
            assign w_smode_in = sat_mode;
`endif
        end else begin : g_next
            localparam int P_HI = hi_off(k - 1, W, CW);
            assign w_ca      = r_a_all[P_HI +: CW];
            assign w_cb      = r_b_all[P_HI +: CW];
            assign w_cin     = r_ctl[k-1].carry;
            assign w_vin     = r_ctl[k-1].valid;
            assign w_lo_next = {w_cs, r_sum_all[lo_off(k - 1, CW) +: k * CW]};
`ifdef PIPE_ADD_ATR_SAT_EN
            assign w_sub_in   = r_sub[k-1];
            assign w_smode_in = r_smode[k-1];
`endif
        end

        pipe_add_atr_chunk #(.CW(CW)) u_chunk (
            .a     (w_ca),
            .b     (w_cb),
            .cin   (w_cin),
            .sum   (w_cs),
            .cout  (w_cout),
            .c_msb (w_cmsb)
        );

        if (k < STAGES - 1) begin : g_mid
            localparam int HI     = W - (k + 1) * CW;
            localparam int HI_OFF = hi_off(k, W, CW);
            logic [HI-1:0] w_ahi;
            logic [HI-1:0] w_bhi;
            logic          w_unused;

            if (k == 0) begin : g_src_in
                assign w_ahi = a[W-1:CW];
                assign w_bhi = w_beff[W-1:CW];
            end else begin : g_src_pipe
                assign w_ahi = r_a_all[hi_off(k - 1, W, CW) + CW +: HI];
                assign w_bhi = r_b_all[hi_off(k - 1, W, CW) + CW +: HI];
            end

            assign w_lo_store = w_lo_next;
            assign w_unused   = w_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_all[HI_OFF +: HI] <= '0;
                    r_b_all[HI_OFF +: HI] <= '0;
`ifdef PIPE_ADD_ATR_SAT_EN
                    r_sub[k]              <= 1'b0;
                    r_smode[k]            <= 1'b0;
`endif
                end else if (w_adv[k]) begin
                    r_a_all[HI_OFF +: HI] <= w_ahi;
                    r_b_all[HI_OFF +: HI] <= w_bhi;
`ifdef PIPE_ADD_ATR_SAT_EN
                    r_sub[k]              <= w_sub_in;
                    r_smode[k]            <= w_smode_in;
`endif
                end
            end
        end else begin : g_last
            logic w_ovf_raw;
            assign w_ovf_raw = w_cmsb ^ w_cout;
`ifdef PIPE_ADD_ATR_SAT_EN
            logic         w_sat;
            logic [W-1:0] w_sat_sum;

            // Top chunk of A is still in w_ca here, so its MSB picks the rail.
            always_comb begin
                w_sat     = 1'b0;
                w_sat_sum = w_lo_next;
                if (w_smode_in) begin
                    if (w_ovf_raw) begin
                        w_sat     = 1'b1;
                        w_sat_sum = w_ca[CW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                    end
                end else if (!w_sub_in && w_cout) begin
                    w_sat     = 1'b1;
                    w_sat_sum = '1;
                end else if (w_sub_in && !w_cout) begin
                    w_sat     = 1'b1;
                    w_sat_sum = '0;
                end
            end

            assign w_lo_store = w_sat_sum;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        r_sat <= 1'b0;
                else if (w_adv[k]) r_sat <= w_vin & w_sat;
            end
`else
            assign w_lo_store = w_lo_next;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        r_ovf <= 1'b0;
                else if (w_adv[k]) r_ovf <= w_vin & w_ovf_raw;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctl[k]                <= '0;
                r_sum_all[LO_OFF +: LO] <= '0;
            end else if (w_adv[k]) begin
                r_ctl[k].valid          <= w_vin;
                r_ctl[k].carry          <= w_vin & w_cout;
                r_sum_all[LO_OFF +: LO] <= w_vin ? w_lo_store : '0;
            end
        end
    end

    assign out_valid = r_ctl[STAGES-1].valid;
    assign co        = r_ctl[STAGES-1].carry;
    assign ovf       = r_ovf;
    assign sum       = r_sum_all[lo_off(STAGES - 1, CW) +: W];
`ifdef PIPE_ADD_ATR_SAT_EN
    assign sat       = r_sat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_add_atr.sv
// ============================================================================
// Module   : tb_pipe_add_atr
// Brief    : Scoreboard bench for pipe_add_atr against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_add_atr;

    localparam int W      = 16;
    localparam int STAGES = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         ci        = 1'b0;
    logic         sub       = 1'b0;
    logic         sat_mode  = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
`ifdef PIPE_ADD_ATR_SAT_EN
    logic         sat;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        logic         sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;

    pipe_add_atr #(.W(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
`ifdef PIPE_ADD_ATR_SAT_EN
        .sat_mode  (sat_mode),
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Whole-word integer arithmetic; saturation rules applied on top.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s, input logic m);
        exp_t        e;
        longint      ux, uy, u, sx, sy, si;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            u  = ux + uy + longint'(c);
            si = sx + sy + longint'(c);
        end else begin
            u  = ux - uy + (longint'(1) << W);
            si = sx - sy;
        end
        e.sum = u[W-1:0];
        e.co  = u[W];
        e.ovf = (si > ((longint'(1) << (W - 1)) - 1)) || (si < -(longint'(1) << (W - 1)));
        e.sat = 1'b0;
`ifdef PIPE_ADD_ATR_SAT_EN
        if (m) begin
            if (e.ovf) begin
                e.sat = 1'b1;
                e.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end else if (!s && e.co) begin
            e.sat = 1'b1;
            e.sum = '1;
        end else if (s && !e.co) begin
            e.sat = 1'b1;
            e.sum = '0;
        end
`else
        if (m) e.sat = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever a result beat is consumed.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (!out_valid) chk("ovf_idle", {31'b0, ovf}, 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", {16'b0, sum}, {16'b0, e.sum});
                    chk("co", {31'b0, co}, {31'b0, e.co});
                    chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`ifdef PIPE_ADD_ATR_SAT_EN
                    chk("sat", {31'b0, sat}, {31'b0, e.sat});
`endif
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input logic m);
        bit done;
        done = 1'b0;
        a = x; b = y; ci = c; sub = s; sat_mode = m; in_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(x, y, c, s, m));
                done = 1'b1;
            end
            cyc();
        end
        in_valid = 1'b0;
        chk("send_accepted", {31'b0, done}, 32'd1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (sb.size() != 0 && i < 100) begin
            cyc();
            i++;
        end
        cyc();
        cyc();
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int           lat, acc, stale, t0;
        logic         pend;
        logic [W-1:0] s_sum;
        logic         s_co, s_ovf;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_co", {31'b0, co}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        cyc();

        // Directed beats and latency
        out_ready = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk("latency", lat, STAGES);
        chk("dir_sum_0100", {16'b0, sum}, 32'h0100);
        chk("dir_co_0100", {31'b0, co}, 32'd0);
        cyc();
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        drain();

        // Back-to-back throughput
        t0 = cyc_cnt;
        for (int i = 0; i < 64; i++)
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("throughput_cycles", cyc_cnt - t0, 32'd64);
        drain();

        // Random traffic with random backpressure
        pend = 1'b0;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                a = rnd_op(); b = rnd_op();
                ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                sat_mode = 1'($urandom_range(0, 1));
                pend = ($urandom_range(0, 3) != 0);
            end
            in_valid = pend;
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, ci, sub, sat_mode));
                pend = 1'b0;
            end
            cyc();
        end
        drain();

        // Full backpressure
        out_ready = 1'b0;
        acc = 0;
        pend = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!pend) begin
                a = rnd_op(); b = rnd_op();
                ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                sat_mode = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(a, b, ci, sub, sat_mode));
                acc++;
                pend = 1'b0;
            end
            cyc();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 32'd4);
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        s_sum = sum; s_co = co; s_ovf = ovf;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("bp_stable_sum", {16'b0, sum}, {16'b0, s_sum});
            chk("bp_stable_co", {31'b0, co}, {31'b0, s_co});
            chk("bp_stable_ovf", {31'b0, ovf}, {31'b0, s_ovf});
            chk("bp_stable_valid", {31'b0, out_valid}, 32'd1);
        end
        cyc();
        drain();

        // Bubble collapse while stalled
        out_ready = 1'b0;
        send(rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        @(negedge clk);
        chk("bub_out_valid", {31'b0, out_valid}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bub_in_ready", {31'b0, in_ready}, 32'd1);
            cyc();
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        @(negedge clk);
        chk("bub_full_in_ready", {31'b0, in_ready}, 32'd0);
        cyc();
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) send(16'h1000 + W'(j), 16'h0011, 1'b0, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        chk("rstm_pre_valid", {31'b0, out_valid}, 32'd1);
        cyc();
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rstm_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstm_sum", {16'b0, sum}, 32'd0);
        chk("rstm_co", {31'b0, co}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
            cyc();
        end
        chk("rstm_no_stale", stale, 32'd0);

`ifdef PIPE_ADD_ATR_SAT_EN
        // Unsigned saturation
        send(16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        chk("sat_sum_ffff", {16'b0, sum}, 32'hFFFF);
        chk("sat_flag", {31'b0, sat}, 32'd1);
        cyc();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0);
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
